// File: rtl/glitch_sequencer.sv
// glitch_sequencer
//   Trigger-driven scheduler for the clock-glitch mux select. After an arm
//   request in IDLE the block latches its configuration, waits for a rising
//   edge on the (asynchronous) trigger, counts a programmable delay, and then
//   emits count_cfg pulses of width_cfg cycles separated by gap_cfg cycles.
//   Every output is a flop so the mux select is hazard-free.
//
// Ports
//   clk_in1    : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   arm        : level; in IDLE latches configs and moves to ARMED
//   abort      : synchronous cancel from ARMED/DELAY/GLITCH/GAP
//   trigger    : asynchronous trigger, synchronised internally
//   delay_cfg  : cycles from detected trigger edge to first pulse (0 = none)
//   width_cfg  : glitch_en high time per pulse (0 treated as 1)
//   gap_cfg    : glitch_en low time between pulses (0 treated as 1)
//   count_cfg  : pulses per trigger (0 treated as 1)
//   glitch_en  : registered glitch enable to the mux
//   armed      : high while waiting for the trigger
//   busy       : high from leaving ARMED until return to IDLE
//   done       : one-cycle pulse after the last pulse completes
//   pulse_cnt  : pulses issued since the last arm
module glitch_sequencer #(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk_in1,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger,
    input  logic [DELAY_W-1:0] delay_cfg,
    input  logic [WIDTH_W-1:0] width_cfg,
    input  logic [WIDTH_W-1:0] gap_cfg,
    input  logic [COUNT_W-1:0] count_cfg,
    output logic               glitch_en,
    output logic               armed,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pulse_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_GLITCH,
        S_GAP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [DELAY_W-1:0] delay;
        logic [WIDTH_W-1:0] width;
        logic [WIDTH_W-1:0] gap;
        logic [COUNT_W-1:0] count;
    } cfg_t;

    localparam logic [DELAY_W-1:0] DLY_ONE = 1;
    localparam logic [WIDTH_W-1:0] WID_ONE = 1;
    localparam logic [COUNT_W-1:0] CNT_ONE = 1;

    state_t             state, state_nx;
    cfg_t               cfg_q, cfg_nx;
    logic [DELAY_W-1:0] dly_cnt, dly_nx;
    // One down-counter serves both the high (width) and low (gap) phases,
    // since only one of them is ever active.
    logic [WIDTH_W-1:0] ph_cnt, ph_nx;
    logic [COUNT_W-1:0] pulse_nx;
    logic               enter_glitch;

    // trig_sync[0..2] = s1, s2, s3. s1/s2 resolve metastability, s3 is the
    // previous s2 value for edge detection.
    logic [2:0]         trig_sync;
    logic               rise;

    assign rise = trig_sync[1] & ~trig_sync[2];

    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            trig_sync <= '0;
        end else begin
            trig_sync <= {trig_sync[1:0], trigger};
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        cfg_nx       = cfg_q;
        dly_nx       = dly_cnt;
        ph_nx        = ph_cnt;
        pulse_nx     = pulse_cnt;
        enter_glitch = 1'b0;

        case (state)
            S_IDLE: begin
                if (arm) begin
                    cfg_nx.delay = delay_cfg;
                    cfg_nx.width = (width_cfg == '0) ? WID_ONE : width_cfg;
                    cfg_nx.gap   = (gap_cfg   == '0) ? WID_ONE : gap_cfg;
                    cfg_nx.count = (count_cfg == '0) ? CNT_ONE : count_cfg;
                    pulse_nx     = '0;
                    state_nx     = S_ARMED;
                end
            end
            S_ARMED: begin
                // abort has priority over a coincident trigger edge
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (rise) begin
                    if (cfg_q.delay != '0) begin
                        state_nx = S_DELAY;
                        dly_nx   = cfg_q.delay - DLY_ONE;
                    end else begin
                        enter_glitch = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (dly_cnt == '0) begin
                    enter_glitch = 1'b1;
                end else begin
                    dly_nx = dly_cnt - DLY_ONE;
                end
            end
            S_GLITCH: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (ph_cnt == '0) begin
                    // pulse_cnt was already bumped on entry to this pulse
                    if (pulse_cnt == cfg_q.count) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_GAP;
                        ph_nx    = cfg_q.gap - WID_ONE;
                    end
                end else begin
                    ph_nx = ph_cnt - WID_ONE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (ph_cnt == '0) begin
                    enter_glitch = 1'b1;
                end else begin
                    ph_nx = ph_cnt - WID_ONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (enter_glitch) begin
            state_nx = S_GLITCH;
            ph_nx    = cfg_q.width - WID_ONE;
            pulse_nx = pulse_cnt + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cfg_q     <= '0;
            dly_cnt   <= '0;
            ph_cnt    <= '0;
            pulse_cnt <= '0;
            glitch_en <= 1'b0;
            armed     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cfg_q     <= cfg_nx;
            dly_cnt   <= dly_nx;
            ph_cnt    <= ph_nx;
            pulse_cnt <= pulse_nx;
            glitch_en <= (state_nx == S_GLITCH);
            armed     <= (state_nx == S_ARMED);
            busy      <= (state_nx == S_DELAY) || (state_nx == S_GLITCH) ||
                         (state_nx == S_GAP)   || (state_nx == S_DONE);
            done      <= (state_nx == S_DONE);
        end
    end

endmodule
